// File: rtl/game_select_ctrl_if.sv
// Bundle of the board-load, button and board-state signals between the
// input front end (master) and the card game controller (slave).
interface game_select_ctrl_if #(
    parameter int MOVE_W = 8
);
    logic              init_valid;
    logic [39:0]       init_status;
    logic [2:0]        init_total;
    logic              btn_left;
    logic              btn_right;
    logic              btn_up;
    logic              btn_down;
    logic              btn_confirm;
    logic              btn_cancel;
    logic [2:0]        total_number;
    logic [39:0]       status;
    logic [3:0]        predict;
    logic              selecting;
    logic [3:0]        cur_select;
    logic [3:0]        selected;
    logic [MOVE_W-1:0] move_cnt;
    logic              done;

    modport master (
        output init_valid, init_status, init_total,
        output btn_left, btn_right, btn_up, btn_down, btn_confirm, btn_cancel,
        input  total_number, status, predict, selecting, cur_select,
        input  selected, move_cnt, done
    );

    modport slave (
        input  init_valid, init_status, init_total,
        input  btn_left, btn_right, btn_up, btn_down, btn_confirm, btn_cancel,
        output total_number, status, predict, selecting, cur_select,
        output selected, move_cnt, done
    );
endinterface

// File: rtl/game_select_ctrl.sv
// Card-merge game controller: owns the 2x5 board, cursor, first pick and move
// counter, and offers a combinational preview of the pending merge result.
module game_select_ctrl #(
    parameter int          ROW_MAX = 5,
    parameter logic [3:0]  EMPTY   = 4'hF,
    parameter int          MOVE_W  = 8
) (
    input  logic              vga_clk,
    input  logic              vga_rst_n,
    game_select_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BROWSE, PICKED, MERGE, CHECK, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        status_reg [10];
    logic [3:0]        status_next [10];
    logic [2:0]        total_reg, total_next;
    logic [3:0]        cur_reg, cur_next;
    logic [3:0]        sel_reg, sel_next;
    logic              selecting_reg, selecting_next;
    logic              done_reg, done_next;
    logic [MOVE_W-1:0] move_reg, move_next;

    logic [2:0]  init_total_fix;
    logic [3:0]  init_masked [10];
    logic [9:0]  live;
    logic [3:0]  live_cnt;

    assign init_total_fix = (bus.init_total == 3'd0 || bus.init_total > 3'(ROW_MAX))
                          ? 3'(ROW_MAX) : bus.init_total;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_card
            localparam int COL = gi % ROW_MAX;
            assign init_masked[gi] = (3'(COL) >= init_total_fix) ? EMPTY
                                   : bus.init_status[gi*4 +: 4];
            assign live[gi]               = (status_reg[gi] != EMPTY);
            assign bus.status[gi*4 +: 4]  = status_reg[gi];
        end
    endgenerate

    assign live_cnt = 4'($countones(live));

    // Cursor arithmetic on (row, col); the active width wraps, empty cards are not skipped.
    logic       cur_row;
    logic [3:0] cur_col, row_base, total_ext, cur_left, cur_right, cur_flip;

    assign cur_row   = (cur_reg >= 4'(ROW_MAX));
    assign cur_col   = cur_row ? cur_reg - 4'(ROW_MAX) : cur_reg;
    assign row_base  = cur_row ? 4'(ROW_MAX) : 4'd0;
    assign total_ext = {1'b0, total_reg};
    assign cur_left  = row_base + ((cur_col == 4'd0) ? total_ext - 4'd1 : cur_col - 4'd1);
    assign cur_right = row_base + ((cur_col == total_ext - 4'd1) ? 4'd0 : cur_col + 4'd1);
    assign cur_flip  = cur_row ? cur_col : cur_col + 4'(ROW_MAX);

    logic [3:0] cur_val, sel_val, merged;
    logic [4:0] sum_raw;

    assign cur_val = status_reg[cur_reg];
    assign sel_val = status_reg[sel_reg];
    assign sum_raw = {1'b0, sel_val} + {1'b0, cur_val};
    assign merged  = (sum_raw >= 5'd10) ? 4'(sum_raw - 5'd10) : sum_raw[3:0];

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            state_reg     <= IDLE;
            status_reg    <= '{default: EMPTY};
            total_reg     <= 3'(ROW_MAX);
            cur_reg       <= 4'd0;
            sel_reg       <= 4'd0;
            selecting_reg <= 1'b0;
            done_reg      <= 1'b0;
            move_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            status_reg    <= status_next;
            total_reg     <= total_next;
            cur_reg       <= cur_next;
            sel_reg       <= sel_next;
            selecting_reg <= selecting_next;
            done_reg      <= done_next;
            move_reg      <= move_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        status_next    = status_reg;
        total_next     = total_reg;
        cur_next       = cur_reg;
        sel_next       = sel_reg;
        selecting_next = selecting_reg;
        done_next      = done_reg;
        move_next      = move_reg;

        if (bus.init_valid) begin
            status_next    = init_masked;
            total_next     = init_total_fix;
            cur_next       = 4'd0;
            selecting_next = 1'b0;
            done_next      = 1'b0;
            move_next      = '0;
            state_next     = CHECK;
        end else begin
            case (state_reg)
                BROWSE, PICKED: begin
                    // Strict priority: at most one button acts per cycle.
                    if (bus.btn_cancel) begin
                        if (state_reg == PICKED) begin
                            selecting_next = 1'b0;
                            state_next     = BROWSE;
                        end
                    end else if (bus.btn_confirm) begin
                        if (state_reg == BROWSE) begin
                            if (cur_val != EMPTY) begin
                                sel_next       = cur_reg;
                                selecting_next = 1'b1;
                                state_next     = PICKED;
                            end
                        end else if (cur_reg == sel_reg) begin
                            selecting_next = 1'b0;
                            state_next     = BROWSE;
                        end else if (cur_val != EMPTY) begin
                            state_next = MERGE;
                        end
                    end else if (bus.btn_left) begin
                        cur_next = cur_left;
                    end else if (bus.btn_right) begin
                        cur_next = cur_right;
                    end else if (bus.btn_up || bus.btn_down) begin
                        cur_next = cur_flip;
                    end
                end
                MERGE: begin
                    status_next[cur_reg] = merged;
                    status_next[sel_reg] = EMPTY;
                    selecting_next       = 1'b0;
                    move_next            = (move_reg == '1) ? move_reg : move_reg + 1'b1;
                    state_next           = CHECK;
                end
                CHECK: begin
                    if (live_cnt <= 4'd1) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BROWSE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.predict = EMPTY;
        if (state_reg == PICKED && cur_reg != sel_reg && cur_val != EMPTY)
            bus.predict = merged;
    end

    assign bus.total_number = total_reg;
    assign bus.selecting    = selecting_reg;
    assign bus.cur_select   = cur_reg;
    assign bus.selected     = sel_reg;
    assign bus.move_cnt     = move_reg;
    assign bus.done         = done_reg;
endmodule

// File: tb/tb_game_select_ctrl.sv
// Directed bench for game_select_ctrl: a rule-level board model checked every
// cycle, plus literal expectations at the notable points of each scenario.
module tb_game_select_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_select_ctrl_if bus ();

    game_select_ctrl dut (
        .vga_clk   (clk),
        .vga_rst_n (rst_n),
        .bus       (bus.slave)
    );

    localparam bit [6:0] B_INIT   = 7'b1000000;
    localparam bit [6:0] B_CANCEL = 7'b0100000;
    localparam bit [6:0] B_CONF   = 7'b0010000;
    localparam bit [6:0] B_LEFT   = 7'b0001000;
    localparam bit [6:0] B_RIGHT  = 7'b0000100;
    localparam bit [6:0] B_UP     = 7'b0000010;
    localparam bit [6:0] B_DOWN   = 7'b0000001;

    localparam int P_IDLE = 0, P_PLAY = 1, P_MERGE = 2, P_CHECK = 3, P_OVER = 4;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b1;

    // Board model: card values, cursor as (row, col), and a phase telling
    // whether the game is idle, interactive, mid-merge, counting, or over.
    int m_st [10];
    int m_total, m_cur, m_sel, m_moves, m_phase;
    bit m_selecting, m_done;

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) m_st[i] = 15;
        m_total = 5; m_cur = 0; m_sel = 0; m_moves = 0;
        m_selecting = 0; m_done = 0; m_phase = P_IDLE;
    endfunction

    function automatic int m_merge_val();
        return (m_st[m_sel] + m_st[m_cur]) % 10;
    endfunction

    function automatic logic [3:0] m_predict();
        if (m_phase == P_PLAY && m_selecting && m_cur != m_sel && m_st[m_cur] != 15)
            return 4'(m_merge_val());
        return 4'hF;
    endfunction

    function automatic logic [39:0] m_packed();
        logic [39:0] v;
        for (int i = 0; i < 10; i++) v[i*4 +: 4] = 4'(m_st[i]);
        return v;
    endfunction

    function automatic void model_step(input bit [6:0] b, input logic [39:0] ist,
                                       input logic [2:0] itot);
        int row, col, live;
        if (b[6]) begin
            m_total = (itot == 0 || itot > 5) ? 5 : int'(itot);
            for (int i = 0; i < 10; i++)
                m_st[i] = ((i % 5) >= m_total) ? 15 : int'(ist[i*4 +: 4]);
            m_cur = 0; m_selecting = 0; m_moves = 0; m_done = 0;
            m_phase = P_CHECK;
            return;
        end
        row = m_cur / 5;
        col = m_cur % 5;
        case (m_phase)
            P_PLAY: begin
                if (b[5]) m_selecting = 0;
                else if (b[4]) begin
                    if (!m_selecting) begin
                        if (m_st[m_cur] != 15) begin m_sel = m_cur; m_selecting = 1; end
                    end else if (m_cur == m_sel) m_selecting = 0;
                    else if (m_st[m_cur] != 15) m_phase = P_MERGE;
                end
                else if (b[3]) m_cur = row * 5 + ((col == 0) ? m_total - 1 : col - 1);
                else if (b[2]) m_cur = row * 5 + ((col == m_total - 1) ? 0 : col + 1);
                else if (b[1] || b[0]) m_cur = (1 - row) * 5 + col;
            end
            P_MERGE: begin
                m_st[m_cur] = m_merge_val();
                m_st[m_sel] = 15;
                m_selecting = 0;
                if (m_moves < 255) m_moves++;
                m_phase = P_CHECK;
            end
            P_CHECK: begin
                live = 0;
                for (int i = 0; i < 10; i++) if (m_st[i] != 15) live++;
                if (live <= 1) begin m_done = 1; m_phase = P_OVER; end
                else m_phase = P_PLAY;
            end
            default: ;
        endcase
    endfunction

    function automatic void check(input string name, input logic [39:0] act,
                                  input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("status",       bus.status,       m_packed());
            check("total_number", 40'(bus.total_number), 40'(m_total));
            check("cur_select",   40'(bus.cur_select),   40'(m_cur));
            check("selecting",    40'(bus.selecting),    40'(m_selecting));
            check("move_cnt",     40'(bus.move_cnt),     40'(m_moves));
            check("done",         40'(bus.done),         40'(m_done));
            check("predict",      40'(bus.predict),      40'(m_predict()));
            if (m_selecting) check("selected", 40'(bus.selected), 40'(m_sel));
        end
    end

    task automatic cyc(input bit [6:0] b, input logic [39:0] ist, input logic [2:0] itot);
        {bus.init_valid, bus.btn_cancel, bus.btn_confirm, bus.btn_left,
         bus.btn_right, bus.btn_up, bus.btn_down} = b;
        bus.init_status = ist;
        bus.init_total  = itot;
        @(posedge clk);
        model_step(b, ist, itot);
        #1;
        {bus.init_valid, bus.btn_cancel, bus.btn_confirm, bus.btn_left,
         bus.btn_right, bus.btn_up, bus.btn_down} = '0;
        bus.init_status = '0;
        bus.init_total  = '0;
        $display("cycle btn=%b cur=%0d sel=%0d selecting=%0d status=%h predict=%h moves=%0d done=%0d",
                 b, bus.cur_select, bus.selected, bus.selecting, bus.status,
                 bus.predict, bus.move_cnt, bus.done);
    endtask

    task automatic press(input bit [6:0] b);
        cyc(b, 40'h0, 3'd0);
    endtask

    task automatic load(input logic [39:0] ist, input logic [2:0] itot);
        cyc(B_INIT, ist, itot);
    endtask

    initial begin
        model_reset();
        {bus.init_valid, bus.btn_cancel, bus.btn_confirm, bus.btn_left,
         bus.btn_right, bus.btn_up, bus.btn_down} = '0;
        bus.init_status = '0;
        bus.init_total  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_status", bus.status, 40'hFFFFFFFFFF);
        check("rst_total", 40'(bus.total_number), 40'd5);
        check("rst_predict", 40'(bus.predict), 40'hF);
        press(B_RIGHT);                               // idle: ignored
        check("idle_cursor", 40'(bus.cur_select), 40'd0);

        // Width 3: cursor wrap and row flips
        load(40'h9876543210, 3'd3);
        check("load3_status", bus.status, 40'hFF765FF210);
        press(0);
        press(B_RIGHT); press(B_RIGHT);
        check("cur_two", 40'(bus.cur_select), 40'd2);
        press(B_RIGHT);
        check("right_wrap", 40'(bus.cur_select), 40'd0);
        press(B_UP);
        check("up_flip", 40'(bus.cur_select), 40'd5);
        press(B_LEFT);
        check("left_wrap", 40'(bus.cur_select), 40'd7);
        press(B_DOWN);
        check("down_flip", 40'(bus.cur_select), 40'd2);
        press(B_CONF | B_LEFT);
        check("conf_left_cur", 40'(bus.cur_select), 40'd2);
        check("conf_left_pick", 40'(bus.selecting), 40'd1);
        press(B_CANCEL | B_CONF);
        check("cancel_wins", 40'(bus.selecting), 40'd0);
        press(B_CONF); press(B_CONF);
        check("self_unpick", 40'(bus.selecting), 40'd0);
        press(B_CONF); press(B_LEFT);
        check("predict_2p1", 40'(bus.predict), 40'h3);
        press(B_CANCEL);
        check("cancel_predict", 40'(bus.predict), 40'hF);

        // Two-card board 7,5: merge into card 1
        load(40'hFFFFFFFF57, 3'd5);
        press(0);
        press(B_CONF); press(B_RIGHT);
        check("predict_7p5", 40'(bus.predict), 40'h2);
        press(B_CONF);
        press(0);
        check("merge_status", bus.status, 40'hFFFFFFFF2F);
        check("merge_moves", 40'(bus.move_cnt), 40'd1);
        check("merge_not_done_yet", 40'(bus.done), 40'd0);
        press(0);
        check("merge_done", 40'(bus.done), 40'd1);

        // Three cards: empty-card confirm, two merges, buttons dead when over
        load(40'hFFFFFFF321, 3'd5);
        press(0);
        press(B_RIGHT); press(B_RIGHT); press(B_RIGHT);
        press(B_CONF);
        check("empty_no_pick", 40'(bus.selecting), 40'd0);
        press(B_LEFT); press(B_CONF); press(B_LEFT);
        check("predict_3p2", 40'(bus.predict), 40'h5);
        press(B_CONF); press(0);
        check("merge1_status", bus.status, 40'hFFFFFFFF51);
        press(0);
        check("still_playing", 40'(bus.done), 40'd0);
        press(B_CONF); press(B_RIGHT);
        check("predict_empty", 40'(bus.predict), 40'hF);
        press(B_CONF);
        check("empty_no_merge", 40'(bus.selecting), 40'd1);
        press(B_LEFT); press(B_LEFT); press(B_CONF);
        press(0);
        check("merge2_status", bus.status, 40'hFFFFFFFFF6);
        check("merge2_moves", 40'(bus.move_cnt), 40'd2);
        press(0);
        press(B_RIGHT); press(B_CONF);
        check("over_cursor", 40'(bus.cur_select), 40'd0);

        // Board {3,4}
        load(40'hFFFFFFFF43, 3'd5);
        press(0);
        press(B_CONF); press(B_RIGHT); press(B_CONF); press(0); press(0);
        check("b34_status", bus.status, 40'hFFFFFFFF7F);
        check("b34_done", 40'(bus.done), 40'd1);
        press(B_LEFT);
        check("b34_ignored", 40'(bus.cur_select), 40'd1);

        // Width 0 and 6 both mean 5; value 14 kept
        load(40'h0123456789, 3'd0);
        check("w0_total", 40'(bus.total_number), 40'd5);
        check("w0_status", bus.status, 40'h0123456789);
        press(0);
        load(40'hFFFFFFFF4E, 3'd6);
        check("w6_total", 40'(bus.total_number), 40'd5);
        press(0);
        press(B_CONF); press(B_RIGHT);
        check("predict_14p4", 40'(bus.predict), 40'h8);

        // New board loaded while a merge is in flight
        press(B_CONF);
        load(40'h0000011111, 3'd5);
        check("init_in_merge", bus.status, 40'h0000011111);
        press(0);

        // Asynchronous reset in the middle of a merge
        load(40'h0123456789, 3'd5);
        press(0);
        press(B_CONF); press(B_RIGHT); press(B_CONF);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_status", bus.status, 40'hFFFFFFFFFF);
        check("rst_mid_moves", 40'(bus.move_cnt), 40'd0);
        check("rst_mid_selecting", 40'(bus.selecting), 40'd0);
        check("rst_mid_cur", 40'(bus.cur_select), 40'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        press(0);
        load(40'hFFFFFFFF12, 3'd2);
        press(0);
        press(B_CONF); press(B_RIGHT); press(B_CONF); press(0); press(0);
        check("post_rst_status", bus.status, 40'hFFFFFFFF3F);
        press(0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
